// File: rtl/uart_bus_master.sv
// uart_bus_master: UART-driven debug initiator for the SoC word memory bus.
// Decodes 'W'/'R' frames from the rx byte stream, issues one bus access and
// streams the status or read data back through the tx handshake.
module uart_bus_master #(
  parameter int BUS_TIMEOUT   = 1024,
  parameter int FRAME_TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        active
);

  localparam int BUS_W = $clog2(BUS_TIMEOUT + 1);
  localparam int FRM_W = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [BUS_W-1:0] BUS_LAST = BUS_W'(BUS_TIMEOUT - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_TIMEOUT - 1);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;
  localparam logic [7:0] RSP_TOUT  = 8'h54;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      resp_q, resp_d;
  logic [1:0]       resp_cnt_q, resp_cnt_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [BUS_W-1:0] bus_cnt_q, bus_cnt_d;
  logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_q     <= '0;
      resp_cnt_q <= '0;
      byte_cnt_q <= '0;
      bus_cnt_q  <= '0;
      frm_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      resp_q     <= resp_d;
      resp_cnt_q <= resp_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      bus_cnt_q  <= bus_cnt_d;
      frm_cnt_q  <= frm_cnt_d;
    end
  end

  // Frame decode, bus access sequencing and response shifting.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    resp_d     = resp_q;
    resp_cnt_d = resp_cnt_q;
    byte_cnt_d = byte_cnt_q;
    bus_cnt_d  = bus_cnt_q;
    frm_cnt_d  = frm_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          cmd_d      = rx_data;
          byte_cnt_d = '0;
          frm_cnt_d  = '0;
          wdata_d    = '0;
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            state_d = S_ADDR;
          end else begin
            resp_d     = {24'h0, RSP_NAK};
            resp_cnt_d = '0;
            state_d    = S_RESP;
          end
        end
      end

      S_ADDR: begin
        if (rx_valid) begin
          frm_cnt_d  = '0;
          addr_d     = {rx_data, addr_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            bus_cnt_d = '0;
            state_d   = (cmd_q == CMD_READ) ? S_BUS : S_DATA;
          end
        end else if (frm_cnt_q == FRM_LAST) begin
          frm_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          frm_cnt_d = frm_cnt_q + FRM_W'(1);
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          frm_cnt_d  = '0;
          wdata_d    = {rx_data, wdata_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            bus_cnt_d = '0;
            state_d   = S_BUS;
          end
        end else if (frm_cnt_q == FRM_LAST) begin
          frm_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          frm_cnt_d = frm_cnt_q + FRM_W'(1);
        end
      end

      S_BUS: begin
        // A ready arriving on the final timeout cycle still wins.
        if (mem_ready) begin
          if (cmd_q == CMD_READ) begin
            resp_d     = mem_rdata;
            resp_cnt_d = 2'd3;
          end else begin
            resp_d     = {24'h0, RSP_ACK};
            resp_cnt_d = '0;
          end
          bus_cnt_d = '0;
          state_d   = S_RESP;
        end else if (bus_cnt_q == BUS_LAST) begin
          resp_d     = {24'h0, RSP_TOUT};
          resp_cnt_d = '0;
          bus_cnt_d  = '0;
          state_d    = S_RESP;
        end else begin
          bus_cnt_d = bus_cnt_q + BUS_W'(1);
        end
      end

      S_RESP: begin
        if (tx_ready) begin
          if (resp_cnt_q == 2'd0) begin
            state_d = S_IDLE;
          end else begin
            resp_d     = {8'h00, resp_q[31:8]};
            resp_cnt_d = resp_cnt_q - 2'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; bus fields are only driven during the access.
  always_comb begin
    tx_valid  = (state_q == S_RESP);
    tx_data   = tx_valid ? resp_q[7:0] : 8'h00;
    mem_valid = (state_q == S_BUS);
    mem_addr  = mem_valid ? {addr_q[31:2], 2'b00} : '0;
    mem_wdata = mem_valid ? wdata_q : '0;
    mem_wstrb = (mem_valid && cmd_q == CMD_WRITE) ? 4'hF : 4'h0;
    active    = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: directed frames push expected bus
// transactions and tx bytes; monitors pop and compare as the DUT presents them.
module tb_uart_bus_master;

  logic        clk;
  logic        resetn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        active;

  uart_bus_master #(.BUS_TIMEOUT(8), .FRAME_TIMEOUT(16)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .active   (active)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          len;
  } bus_t;

  int   checks = 0;
  int   fails  = 0;
  bus_t exp_bus_q[$];
  logic [7:0] exp_tx_q[$];
  int   ready_delay = 0;
  int   tx_stall = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: pulses mem_ready on the ready_delay-th valid cycle (never if negative).
  initial begin
    int vcnt;
    vcnt = 0;
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_valid && resetn) begin
        mem_ready = (vcnt == ready_delay);
        vcnt++;
      end else begin
        mem_ready = 1'b0;
        vcnt = 0;
      end
    end
  end

  // Transmitter model: accepts each byte after tx_stall idle cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_ready) begin
        tx_ready = 1'b0;
        wcnt = 0;
      end else if (tx_valid) begin
        if (wcnt >= tx_stall) tx_ready = 1'b1;
        else wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: compares bus requests and tx bytes against the scoreboard queues.
  initial begin
    bus_t cur;
    logic mv_prev;
    int   vlen;
    mv_prev = 1'b0;
    vlen = 0;
    cur = '{addr: 32'h0, wdata: 32'h0, wstrb: 4'h0, len: 0};
    forever begin
      @(negedge clk);
      if (!resetn) begin
        exp_bus_q.delete();
        exp_tx_q.delete();
        mv_prev = 1'b0;
      end else begin
        if (mem_valid) begin
          if (!mv_prev) begin
            vlen = 0;
            if (exp_bus_q.size() == 0) begin
              check("bus_unexpected", {31'h0, mem_valid}, 32'h0);
              cur = '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb, len: 0};
            end else begin
              cur = exp_bus_q.pop_front();
            end
          end
          vlen++;
          check("mem_addr", mem_addr, cur.addr);
          check("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, cur.wstrb});
          if (cur.wstrb == 4'hF) check("mem_wdata", mem_wdata, cur.wdata);
        end else if (mv_prev) begin
          check("mem_valid_len", vlen, cur.len);
        end
        mv_prev = mem_valid;

        if (tx_valid) begin
          if (exp_tx_q.size() == 0) begin
            check("tx_unexpected", {31'h0, tx_valid}, 32'h0);
          end else begin
            check("tx_data", {24'h0, tx_data}, {24'h0, exp_tx_q[0]});
            if (tx_ready) void'(exp_tx_q.pop_front());
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (active && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_active"}, {31'h0, active}, 32'h0);
    check({name, "_txq"}, exp_tx_q.size(), 32'h0);
    check({name, "_busq"}, exp_bus_q.size(), 32'h0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
    check({name, "_tx_data"}, {24'h0, tx_data}, 32'h0);
    check({name, "_mem_valid"}, {31'h0, mem_valid}, 32'h0);
    check({name, "_mem_addr"}, mem_addr, 32'h0);
    check({name, "_mem_wdata"}, mem_wdata, 32'h0);
    check({name, "_mem_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
    check({name, "_active"}, {31'h0, active}, 32'h0);
  endtask

  // Watchdog bound on the whole run.
  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1);
  end

  initial begin
    int n;
    resetn    = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Write: ready on the 4th valid cycle, single ACK byte.
    ready_delay = 3;
    tx_stall = 0;
    exp_bus_q.push_back('{addr: 32'h8000_0000, wdata: 32'hDEAD_BEEF, wstrb: 4'hF, len: 4});
    exp_tx_q.push_back(8'h06);
    send_byte(8'h57);
    send_word(32'h8000_0000);
    send_word(32'hDEAD_BEEF);
    wait_done("write");

    // Read with misaligned host address and stalled transmitter.
    mem_rdata = 32'h1234_5678;
    tx_stall = 10;
    exp_bus_q.push_back('{addr: 32'h1000_0004, wdata: 32'h0, wstrb: 4'h0, len: 4});
    exp_tx_q.push_back(8'h78);
    exp_tx_q.push_back(8'h56);
    exp_tx_q.push_back(8'h34);
    exp_tx_q.push_back(8'h12);
    send_byte(8'h52);
    send_word(32'h1000_0005);
    wait_done("read");

    // Unknown command: NAK, no bus access.
    tx_stall = 2;
    exp_tx_q.push_back(8'h15);
    send_byte(8'h41);
    wait_done("badcmd");

    // Bus timeout: ready never comes, valid held for exactly BUS_TIMEOUT cycles.
    ready_delay = -1;
    tx_stall = 0;
    exp_bus_q.push_back('{addr: 32'h0000_0100, wdata: 32'h1122_3344, wstrb: 4'hF, len: 8});
    exp_tx_q.push_back(8'h54);
    send_byte(8'h57);
    send_word(32'h0000_0100);
    send_word(32'h1122_3344);
    wait_done("bustimeout");

    // Frame timeout after a partial frame, then a full read.
    send_byte(8'h57);
    send_byte(8'h01);
    n = 0;
    while (active && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("frame_timeout_cycles", n, 32'd16);
    check("frame_timeout_active", {31'h0, active}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    ready_delay = 0;
    mem_rdata = 32'hA5A5_0F0F;
    exp_bus_q.push_back('{addr: 32'h2000_0008, wdata: 32'h0, wstrb: 4'h0, len: 1});
    exp_tx_q.push_back(8'h0F);
    exp_tx_q.push_back(8'h0F);
    exp_tx_q.push_back(8'hA5);
    exp_tx_q.push_back(8'hA5);
    send_byte(8'h52);
    send_word(32'h2000_0008);
    wait_done("after_frame_timeout");

    // Reset during BUS: outputs clear on the next edge.
    ready_delay = -1;
    exp_bus_q.push_back('{addr: 32'h0000_0040, wdata: 32'hCAFE_F00D, wstrb: 4'hF, len: 8});
    send_byte(8'h57);
    send_word(32'h0000_0040);
    send_word(32'hCAFE_F00D);
    n = 0;
    while (!mem_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_mid_busy", {31'h0, mem_valid}, 32'h1);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("rst_mid");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Read with stray rx bytes during RESP: still exactly four bytes out.
    ready_delay = 1;
    tx_stall = 10;
    mem_rdata = 32'h0BAD_F00D;
    exp_bus_q.push_back('{addr: 32'h3000_0010, wdata: 32'h0, wstrb: 4'h0, len: 2});
    exp_tx_q.push_back(8'h0D);
    exp_tx_q.push_back(8'hF0);
    exp_tx_q.push_back(8'hAD);
    exp_tx_q.push_back(8'h0B);
    send_byte(8'h52);
    send_word(32'h3000_0013);
    n = 0;
    while (!tx_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("resp_started", {31'h0, tx_valid}, 32'h1);
    send_byte(8'h57);
    repeat (4) @(posedge clk);
    #1;
    send_byte(8'h41);
    wait_done("rx_in_resp");
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("post_resp_active", {31'h0, active}, 32'h0);
    check("post_resp_tx_valid", {31'h0, tx_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Host-driven debug initiator on the SoC word memory bus (mem_valid/mem_ready), the opposite end of the CPU-side peripheral responders.
- Takes command bytes from the rx_uart byte stream, issues single-word reads and writes, and returns status/data bytes to tx_uart.
- Used for loading and poking SDRAM/BRAM/IO while the CPU is held off the bus. The top-level mux selects this master while `active`=1.

Parameters:
- BUS_TIMEOUT, 1024: cycles to wait for mem_ready before aborting a bus access.
- FRAME_TIMEOUT, 1_000_000: idle cycles between bytes of a partial frame before the frame is discarded.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- tx_valid  out  1  byte to transmit is valid
- tx_data  out  8  byte to transmit
- tx_ready  in  1  transmitter accepts byte when tx_valid&&tx_ready
- mem_valid  out  1  bus request
- mem_addr  out  32  word address, [1:0] always 0
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'hF write, 4'h0 read
- mem_rdata  in  32  read data, sampled when mem_ready=1
- mem_ready  in  1  one-cycle completion pulse
- active  out  1  high from first accepted command byte until the response is fully sent

Behaviour:
- Reset: resetn is synchronous, active-low; clock clk. While resetn=0 all outputs are 0 and state=IDLE. Reset mid-transaction drops mem_valid on the next edge and loses the response.
- Frame format (multi-byte fields little-endian):
  - 'W'(0x57) + addr[4] + data[4] -> response 0x06
  - 'R'(0x52) + addr[4] -> response data[4]
  - any other first byte -> response 0x15, no bus access
  - bus timeout -> response 0x54 in place of the normal response
- States:
  - IDLE: on rx_valid, latch cmd and set active=1. 'W'/'R' -> ADDR; else load 0x15 -> RESP.
  - ADDR: collect 4 bytes into a shift register (byte0 -> [7:0]). After the 4th byte, 'R' -> BUS and 'W' -> DATA.
  - DATA: collect 4 bytes, then -> BUS.
  - BUS: mem_valid=1 with addr/wdata/wstrb held stable.
    - mem_ready=1 on cycle N: capture mem_rdata, mem_valid=0 on N+1, -> RESP.
    - No mem_ready for BUS_TIMEOUT cycles: mem_valid=0, load 0x54, -> RESP.
    - mem_ready asserted in the same cycle the timeout expires counts as success.
  - RESP: present bytes in order, one byte per tx_valid&&tx_ready handshake. tx_data holds until accepted. Read data goes out byte0 first. After the last byte: tx_valid=0, active=0, -> IDLE.
- mem_addr is {addr[31:2],2'b00}; host-supplied addr[1:0] is ignored.
- mem_valid rises exactly one cycle after the final frame byte strobe.
- rx_valid in BUS or RESP: byte discarded, no state change.
- Frame timeout: counter reset on every rx_valid in ADDR/DATA. Reaching FRAME_TIMEOUT -> IDLE, active=0, no response. Counter idle in other states.
- Byte counter is 2 bits and wraps 3->0 to advance state.
- Counters sized $clog2(param+1) and never wrap past their limit.

Test Plan:
- Write: 57 00 00 00 80 EF BE AD DE.
  - Expect one mem_valid pulse train: addr=0x80000000, wdata=0xDEADBEEF, wstrb=F.
  - Responder ready after 3 cycles -> mem_valid low next cycle; tx 0x06; active 0 afterwards.
- Read: 52 05 00 00 10 with mem_rdata=0x12345678.
  - Expect mem_addr=0x10000004, wstrb=0.
  - tx 78 56 34 12 in order, with tx_ready stalled 10 cycles per byte and tx_data stable throughout.
- Bad command 0x41 -> no mem_valid; tx 0x15.
- Bus timeout with BUS_TIMEOUT=8 and ready never asserted -> mem_valid high exactly 8 cycles; tx 0x54.
- Frame timeout with FRAME_TIMEOUT=16: send 57 01 then stop.
  - After 16 cycles return to IDLE with active=0 and no tx.
  - A subsequent full 'R' frame succeeds.
- Reset mid-transaction: resetn low during BUS -> all outputs 0 next edge. Extra rx bytes sent during RESP are ignored, and the response still has exactly 4 bytes.
